// File: rtl/frame_stats_pkg.sv
// Shared types and width helpers for the frame statistics block.
package frame_stats_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 36;
  localparam int DEF_DEPTH = 256;
  localparam int SUM_WIDTH = DEF_WIDTH + $clog2(DEF_DEPTH);
  localparam int SQ_WIDTH  = 2 * DEF_WIDTH;

  function automatic int sq_width_f(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/frame_stats_sat_accumulator.sv
// Unsigned accumulator that clamps at its all-ones value instead of wrapping.
module sat_accumulator #(
  parameter int ACC_WIDTH = 48,
  parameter int ADD_WIDTH = 72
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [ADD_WIDTH-1:0] add_i,
  output logic [ACC_WIDTH-1:0] next_o
);

  localparam int EXT_W = ((ADD_WIDTH > ACC_WIDTH) ? ADD_WIDTH : ACC_WIDTH) + 1;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [EXT_W-1:0]     w_sum;

  // Saturating next value; any carry above ACC_WIDTH clamps to all ones
  always_comb begin
    w_sum = {{(EXT_W-ACC_WIDTH){1'b0}}, r_acc} + {{(EXT_W-ADD_WIDTH){1'b0}}, add_i};
    if (|w_sum[EXT_W-1:ACC_WIDTH]) begin
      next_o = {ACC_WIDTH{1'b1}};
    end else begin
      next_o = w_sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else if (clr_i) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else if (en_i) begin
      r_acc <= next_o;
    end
  end

endmodule

// File: rtl/frame_stats.sv
// Per-frame sum / energy statistics over DEPTH streamed samples.
// Peak magnitude tracking is compiled in with FRAME_STATS_PEAK_EN.
module frame_stats
  import frame_stats_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int CNT_WIDTH    = $clog2(DEPTH) + 1,
  parameter int SQ_SHIFT     = 24,
  parameter int ENERGY_WIDTH = 48
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         frame_start_i,
  input  logic [WIDTH-1:0]             sample_i,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  output logic [WIDTH+CNT_WIDTH-2:0]   sum_o,
  output logic [ENERGY_WIDTH-1:0]      energy_o,
  output logic [WIDTH-1:0]             peak_o,
  output logic [CNT_WIDTH-2:0]         peak_idx_o,
  output logic                         stats_valid_o,
  input  logic                         stats_ready_i,
  output logic                         frame_error_o,
  output logic                         busy_o,
  output logic [CNT_WIDTH-1:0]         sample_count_o
);

  localparam int SUM_W = WIDTH + CNT_WIDTH - 1;
  localparam int SQ_W  = sq_width_f(WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e                  r_state;
  logic                    r_start_pending;
  logic                    r_frame_error;
  logic                    r_sq_vld;
  logic [CNT_WIDTH-1:0]    r_count;
  logic [SUM_W-1:0]        r_sum;
  logic [SUM_W-1:0]        r_sum_out;
  logic [SQ_W-1:0]         r_sq_q;
  logic [ENERGY_WIDTH-1:0] r_energy_out;

  logic                    w_accept;
  logic                    w_restart;
  logic                    w_hs;
  logic                    w_begin;
  logic                    w_load;
  logic [SUM_W-1:0]        w_sample_sext;
  logic [SQ_W-1:0]         w_sample_ext;
  logic [SQ_W-1:0]         w_sq;
  logic [ENERGY_WIDTH-1:0] w_energy_next;

  assign w_accept  = sample_valid_i && (r_state == ACCUM);
  assign w_restart = frame_start_i && ((r_state == ACCUM) || (r_state == DRAIN));
  assign w_hs      = (r_state == OUTPUT) && stats_ready_i;
  assign w_load    = (r_state == DRAIN) && !frame_start_i;

  // Square of the sign-extended sample; the true value always fits in SQ_W bits
  assign w_sample_sext = {{(SUM_W-WIDTH){sample_i[WIDTH-1]}}, sample_i};
  assign w_sample_ext  = {{(SQ_W-WIDTH){sample_i[WIDTH-1]}}, sample_i};
  assign w_sq          = w_sample_ext * w_sample_ext;

  always_comb begin
    w_begin = 1'b0;
    case (r_state)
      IDLE:         w_begin = frame_start_i || r_start_pending;
      ACCUM, DRAIN: w_begin = frame_start_i;
      OUTPUT:       w_begin = stats_ready_i && (frame_start_i || r_start_pending);
      default:      w_begin = 1'b0;
    endcase
  end

  // Control FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state         <= IDLE;
      r_start_pending <= 1'b0;
      r_frame_error   <= 1'b0;
    end else begin
      r_frame_error <= w_restart;
      case (r_state)
        IDLE: begin
          if (w_begin) begin
            r_state         <= ACCUM;
            r_start_pending <= 1'b0;
          end
        end
        ACCUM: begin
          if (frame_start_i) begin
            r_state <= ACCUM;
          end else if (w_accept && (r_count == LAST_IDX)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: r_state <= frame_start_i ? ACCUM : OUTPUT;
        OUTPUT: begin
          if (w_hs) begin
            r_state         <= w_begin ? ACCUM : IDLE;
            r_start_pending <= 1'b0;
          end else if (frame_start_i) begin
            r_start_pending <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sum, square pipeline, sample count and result capture
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sum        <= {SUM_W{1'b0}};
      r_count      <= {CNT_WIDTH{1'b0}};
      r_sq_q       <= {SQ_W{1'b0}};
      r_sq_vld     <= 1'b0;
      r_sum_out    <= {SUM_W{1'b0}};
      r_energy_out <= {ENERGY_WIDTH{1'b0}};
    end else begin
      if (w_begin) begin
        r_sum    <= {SUM_W{1'b0}};
        r_count  <= {CNT_WIDTH{1'b0}};
        r_sq_q   <= {SQ_W{1'b0}};
        r_sq_vld <= 1'b0;
      end else if (w_accept) begin
        r_sum    <= r_sum + w_sample_sext;
        r_sq_q   <= w_sq >> SQ_SHIFT;
        r_count  <= r_count + CNT_ONE;
        r_sq_vld <= 1'b1;
      end else begin
        r_sq_vld <= 1'b0;
        if (w_hs) begin
          r_count <= {CNT_WIDTH{1'b0}};
        end
      end
      if (w_load) begin
        r_sum_out    <= r_sum;
        r_energy_out <= w_energy_next;
      end
    end
  end

  // Energy lags the square register by one cycle, so DRAIN folds in the last square
  sat_accumulator #(
    .ACC_WIDTH (ENERGY_WIDTH),
    .ADD_WIDTH (SQ_W)
  ) u_energy (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_begin),
    .en_i   (r_sq_vld),
    .add_i  (r_sq_q),
    .next_o (w_energy_next)
  );

`ifdef FRAME_STATS_PEAK_EN
  logic [WIDTH-1:0]     w_abs;
  logic [WIDTH-1:0]     r_peak;
  logic [WIDTH-1:0]     r_peak_out;
  logic [CNT_WIDTH-2:0] r_peak_idx;
  logic [CNT_WIDTH-2:0] r_peak_idx_out;

  assign w_abs = sample_i[WIDTH-1] ? (~sample_i + {{(WIDTH-1){1'b0}}, 1'b1}) : sample_i;

  // Strict greater-than keeps the first index on ties
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_peak         <= {WIDTH{1'b0}};
      r_peak_idx     <= {(CNT_WIDTH-1){1'b0}};
      r_peak_out     <= {WIDTH{1'b0}};
      r_peak_idx_out <= {(CNT_WIDTH-1){1'b0}};
    end else begin
      if (w_begin) begin
        r_peak     <= {WIDTH{1'b0}};
        r_peak_idx <= {(CNT_WIDTH-1){1'b0}};
      end else if (w_accept && (w_abs > r_peak)) begin
        r_peak     <= w_abs;
        r_peak_idx <= r_count[CNT_WIDTH-2:0];
      end
      if (w_load) begin
        r_peak_out     <= r_peak;
        r_peak_idx_out <= r_peak_idx;
      end
    end
  end

  assign peak_o     = r_peak_out;
  assign peak_idx_o = r_peak_idx_out;
`else
  assign peak_o     = {WIDTH{1'b0}};
  assign peak_idx_o = {(CNT_WIDTH-1){1'b0}};
`endif

  assign sample_ready_o = (r_state == ACCUM);
  assign busy_o         = (r_state != IDLE);
  assign stats_valid_o  = (r_state == OUTPUT);
  assign frame_error_o  = r_frame_error;
  assign sum_o          = r_sum_out;
  assign energy_o       = r_energy_out;
  assign sample_count_o = r_count;

endmodule

// File: tb/tb_frame_stats.sv
// Self-checking bench for frame_stats: directed table, random frames vs model, corner sequences.
module tb_frame_stats;

  localparam int W  = 36;
  localparam int D  = 8;
  localparam int CW = 4;
  localparam int SH = 0;
  localparam int EW = 48;
  localparam logic [EW-1:0] EMAX = {EW{1'b1}};

  logic clk = 1'b0;
  logic rst_n, frame_start, valid, stats_ready;
  logic [W-1:0] sample;
  logic ready, stats_valid, frame_error, busy;
  logic signed [W+CW-2:0] sum;
  logic [EW-1:0] energy;
  logic [W-1:0] peak;
  logic [CW-2:0] peak_idx;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frame_stats #(.WIDTH(W), .DEPTH(D), .SQ_SHIFT(SH), .ENERGY_WIDTH(EW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .frame_start_i  (frame_start),
    .sample_i       (sample),
    .sample_valid_i (valid),
    .sample_ready_o (ready),
    .sum_o          (sum),
    .energy_o       (energy),
    .peak_o         (peak),
    .peak_idx_o     (peak_idx),
    .stats_valid_o  (stats_valid),
    .stats_ready_i  (stats_ready),
    .frame_error_o  (frame_error),
    .busy_o         (busy),
    .sample_count_o (count)
  );

  typedef logic [D-1:0][W-1:0] frame_t;
  typedef struct {
    string          name;
    frame_t         s;
    longint         sum;
    logic [EW-1:0]  energy;
    logic [W-1:0]   peak;
    logic [CW-2:0]  idx;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pk_exp(input logic [W-1:0] p);
`ifdef FRAME_STATS_PEAK_EN
    return p;
`else
    return {W{1'b0}} & p & {W{1'b0}};
`endif
  endfunction

  function automatic logic [CW-2:0] ix_exp(input logic [CW-2:0] i);
`ifdef FRAME_STATS_PEAK_EN
    return i;
`else
    return {(CW-1){1'b0}} & i;
`endif
  endfunction

  // Reference: plain arithmetic over the whole frame; clamping the total equals clamping a running sum of non-negatives
  task automatic model(input frame_t s, output longint sm, output logic [EW-1:0] en,
                       output logic [W-1:0] pk, output logic [CW-2:0] ix);
    logic [79:0] tot;
    logic [79:0] a;
    logic signed [W-1:0] v;
    longint lv;
    tot = 80'd0; sm = 0; pk = '0; ix = '0;
    for (int k = 0; k < D; k++) begin
      v = s[k];
      lv = v;
      a = (lv < 0) ? 80'(-lv) : 80'(lv);
      tot += (a * a) >> SH;
      sm += lv;
      if (a > 80'(pk)) begin
        pk = a[W-1:0];
        ix = (CW-1)'(k);
      end
    end
    en = (tot > 80'(EMAX)) ? EMAX : tot[EW-1:0];
    pk = pk_exp(pk);
    ix = ix_exp(ix);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] v);
    int guard;
    guard = 0;
    while ($urandom_range(0, 3) == 0) begin
      valid = 1'b0;
      sample = W'($urandom);
      tick();
    end
    valid = 1'b1;
    sample = v;
    while (!ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("ready_timeout", {79'd0, ready}, 80'd1);
    tick();
    valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t s);
    for (int k = 0; k < D; k++) send(s[k]);
  endtask

  // Called right after the last accept edge: DRAIN now, OUTPUT one cycle later
  task automatic expect_result(input string nm, input longint sm, input logic [EW-1:0] en,
                               input logic [W-1:0] pk, input logic [CW-2:0] ix);
    int guard;
    guard = 0;
    check({nm, "_drain_novalid"}, {79'd0, stats_valid}, 80'd0);
    tick();
    check({nm, "_latency"}, {79'd0, stats_valid}, 80'd1);
    while (!stats_valid && guard < 10) begin
      tick();
      guard++;
    end
    check({nm, "_sum"}, sum, sm);
    check({nm, "_energy"}, energy, en);
    check({nm, "_peak"}, peak, pk);
    check({nm, "_peak_idx"}, peak_idx, ix);
    check({nm, "_count"}, count, 80'(D));
    check({nm, "_ready_low"}, {79'd0, ready}, 80'd0);
  endtask

  task automatic take(input string nm);
    stats_ready = 1'b1;
    tick();
    stats_ready = 1'b0;
    check({nm, "_count_cleared"}, count, 80'd0);
    check({nm, "_valid_dropped"}, {79'd0, stats_valid}, 80'd0);
    check({nm, "_idle"}, {79'd0, busy}, 80'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c2[8];
    frame_t rf;
    logic [63:0] r64;
    longint sm;
    logic [EW-1:0] en;
    logic [W-1:0] pk;
    logic [CW-2:0] ix;

    c2 = '{3, -7, 7, 2, -7, 0, 1, 1};
    for (int k = 0; k < D; k++) begin
      tbl[0].s[k] = W'(k + 1);
      tbl[1].s[k] = 36'h8_0000_0000;
      tbl[2].s[k] = W'(c2[k]);
      tbl[3].s[k] = 36'h0_0000_0000;
    end
    tbl[0].name = "ramp";  tbl[0].sum = 36;  tbl[0].energy = 48'd204;
    tbl[0].peak = pk_exp(36'd8); tbl[0].idx = ix_exp(3'd7);
    tbl[1].name = "minneg"; tbl[1].sum = -64'sd274877906944; tbl[1].energy = EMAX;
    tbl[1].peak = pk_exp(36'h8_0000_0000); tbl[1].idx = ix_exp(3'd0);
    tbl[2].name = "ties";  tbl[2].sum = 0;   tbl[2].energy = 48'd162;
    tbl[2].peak = pk_exp(36'd7); tbl[2].idx = ix_exp(3'd1);
    tbl[3].name = "zeros"; tbl[3].sum = 0;   tbl[3].energy = 48'd0;
    tbl[3].peak = pk_exp(36'd0); tbl[3].idx = ix_exp(3'd0);

    rst_n = 1'b0; frame_start = 1'b0; valid = 1'b0; sample = '0; stats_ready = 1'b0;
    repeat (3) tick();
    check("rst_ready", {79'd0, ready}, 80'd0);
    check("rst_busy", {79'd0, busy}, 80'd0);
    check("rst_valid", {79'd0, stats_valid}, 80'd0);
    check("rst_error", {79'd0, frame_error}, 80'd0);
    check("rst_sum", sum, 80'd0);
    check("rst_energy", energy, 80'd0);
    check("rst_count", count, 80'd0);
    rst_n = 1'b1;
    tick();

    // Valid without a frame start must never be accepted
    valid = 1'b1;
    sample = 36'd5;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_no_accept", {77'd0, ready, stats_valid, busy}, 80'd0);
    end
    valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      start();
      send_frame(tbl[i].s);
      expect_result(tbl[i].name, tbl[i].sum, tbl[i].energy, tbl[i].peak, tbl[i].idx);
      take(tbl[i].name);
    end

    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < D; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          r64 = {$urandom, $urandom};
          rf[k] = r64[W-1:0];
        end else begin
          rf[k] = W'(int'($urandom_range(0, 2000)) - 1000);
        end
      end
      model(rf, sm, en, pk, ix);
      start();
      send_frame(rf);
      expect_result("random", sm, en, pk, ix);
      take("random");
    end

    // Held result with a frame start queued while waiting for the consumer
    start();
    send_frame(tbl[0].s);
    expect_result("hold", 36, 48'd204, pk_exp(36'd8), ix_exp(3'd7));
    for (int c = 0; c < 10; c++) begin
      frame_start = (c == 3);
      tick();
      check("hold_valid", {79'd0, stats_valid}, 80'd1);
      check("hold_sum", sum, 80'd36);
      check("hold_energy", energy, 80'd204);
      check("hold_no_error", {79'd0, frame_error}, 80'd0);
    end
    frame_start = 1'b0;
    stats_ready = 1'b1;
    tick();
    stats_ready = 1'b0;
    check("pending_accum", {79'd0, ready}, 80'd1);
    check("pending_count", count, 80'd0);
    check("pending_novalid", {79'd0, stats_valid}, 80'd0);

    // Restart mid-frame discards the partial sums
    for (int k = 0; k < 3; k++) send(36'd100);
    check("partial_count", count, 80'd3);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("restart_error", {79'd0, frame_error}, 80'd1);
    check("restart_count", count, 80'd0);
    check("restart_ready", {79'd0, ready}, 80'd1);
    tick();
    check("restart_error_pulse", {79'd0, frame_error}, 80'd0);
    for (int k = 0; k < D; k++) send(36'd1);
    expect_result("restart", 8, 48'd8, pk_exp(36'd1), ix_exp(3'd0));
    take("restart");

    // Reset in the middle of a frame
    start();
    for (int k = 0; k < 5; k++) send(36'd7);
    rst_n = 1'b0;
    tick();
    check("midrst_ready", {79'd0, ready}, 80'd0);
    check("midrst_busy", {79'd0, busy}, 80'd0);
    check("midrst_sum", sum, 80'd0);
    check("midrst_energy", energy, 80'd0);
    check("midrst_count", count, 80'd0);
    check("midrst_peak", {peak_idx, peak}, 80'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("midrst_no_result", {78'd0, stats_valid, busy}, 80'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/frame_stats.md
Name: frame_stats

Overview:
- Downstream consumer of the ping-pong RAM buffer's read side.
- Each time a full buffer is handed over, it streams exactly DEPTH signed samples in with a valid/ready handshake.
- It accumulates per-frame statistics (sum and truncated energy), plus the peak when the optional feature is compiled in.
- It presents one result record per frame on a valid/ready output toward the control/UART stage.

Parameters:
- WIDTH, 36, sample width (signed); matches the buffer data width.
- DEPTH, 256, samples per frame; matches the buffer depth.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the sample counter.
- SQ_SHIFT, 24, right shift applied to each square before it is accumulated.
- ENERGY_WIDTH, 48, width of the energy accumulator and of energy_o.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- frame_start_i  in  1  one-cycle pulse: a new frame is available (driven by the buffer's ready pulse)
- sample_i  in  WIDTH  signed sample
- sample_valid_i  in  1  sample_i is valid
- sample_ready_o  out  1  block accepts a sample this cycle
- sum_o  out  WIDTH+CNT_WIDTH-1  signed frame sum
- energy_o  out  ENERGY_WIDTH  saturated sum of (sample^2 >> SQ_SHIFT)
- peak_o  out  WIDTH  maximum |sample| (unsigned)
- peak_idx_o  out  CNT_WIDTH-1  index of the first occurrence of the peak
- stats_valid_o  out  1  result record valid
- stats_ready_i  in  1  consumer takes the record
- frame_error_o  out  1  one-cycle pulse: a frame was restarted mid-accumulation
- busy_o  out  1  state != IDLE
- sample_count_o  out  CNT_WIDTH  samples accepted in the current frame

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is synchronous, active-low.
- Reset values:
  - state = IDLE.
  - All outputs 0: sample_ready_o, stats_valid_o, frame_error_o, busy_o, sum_o, energy_o, peak_o, peak_idx_o, sample_count_o.
  - Accumulators, square pipeline register and start_pending all cleared.
- Handshake: a sample is accepted when sample_valid_i && sample_ready_o. sample_ready_o = (state == ACCUM), decoded combinationally from the state register.
- IDLE:
  - Ready is low.
  - On frame_start_i (or start_pending set): clear the accumulators, clear count and start_pending, go to ACCUM.
- ACCUM:
  - Per accepted sample:
    - sum += sign-extended sample.
    - sq_q <= (sample*sample) >> SQ_SHIFT, with a 2*WIDTH-bit unsigned product.
    - count += 1.
  - Energy pipeline: one cycle after sq_q is loaded, energy += sq_q. The sum saturates at 2^ENERGY_WIDTH-1 and never wraps.
  - The accept that makes count == DEPTH moves the state to DRAIN, so ready is low on the next cycle.
  - Valid bubbles are allowed; count advances only on accept.
- DRAIN: one cycle. The final sq_q is added to energy, the result registers are loaded, then the state goes to OUTPUT.
- OUTPUT:
  - stats_valid_o = 1; all result outputs are held stable until stats_ready_i.
  - On the handshake: if start_pending or frame_start_i, go to ACCUM (cleared); otherwise go to IDLE.
- frame_start_i collisions:
  - In ACCUM or DRAIN: frame_error_o pulses for one cycle; the partial frame is discarded; accumulators and count are cleared; state = ACCUM.
  - In OUTPUT without a handshake that cycle: set start_pending; no error.
- sum cannot overflow: DEPTH * 2^(WIDTH-1) fits in WIDTH+log2(DEPTH) bits.
- Maximum square: (-2^(WIDTH-1))^2 = 2^(2W-2), fits in the unsigned product.
- sample_count_o shows the live count; after the handshake it shows 0.
- A reset asserted in any state returns to the reset values on the next edge; no result is emitted for the interrupted frame.

Optional Feature:
- Macro: FRAME_STATS_PEAK_EN.
- Defined:
  - Tracks |sample| per accept and updates peak_o when |sample| > current peak (strict greater-than, so the first index wins).
  - peak_idx_o = count at that accept.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable in the unsigned WIDTH-bit peak_o.
- Undefined: peak_o and peak_idx_o are tied to 0; no peak logic is synthesised.

Decomposition:
- Shared package frame_stats_pkg holds:
  - the state enum (IDLE, ACCUM, DRAIN, OUTPUT);
  - localparams derived from WIDTH/DEPTH (SUM_WIDTH, SQ_WIDTH).
- Sub-module sat_accumulator: unsigned add with saturation at 2^ENERGY_WIDTH-1, plus a clear input. Used for energy.

Test Plan:
1. After reset, sample_valid_i=1 with no frame_start_i for 20 cycles -> sample_ready_o=0, stats_valid_o=0, busy_o=0.
2. DEPTH=8, SQ_SHIFT=0, pulse start, then samples 1..8 with random valid bubbles -> sum_o=36, energy_o=204, peak_o=8, peak_idx_o=7, stats_valid_o asserted 2 cycles after the 8th accept.
3. WIDTH=36, DEPTH=8, SQ_SHIFT=0, ENERGY_WIDTH=48, all samples -2^35 -> sum_o=-2^38, energy_o=2^48-1 (saturated), peak_o=2^35, peak_idx_o=0.
4. stats_ready_i held low 10 cycles with frame_start_i pulsed at cycle 3 of OUTPUT -> outputs stable, frame_error_o=0, ACCUM entered on the cycle after the handshake.
5. frame_start_i after 3 accepted samples (values 100) -> frame_error_o single pulse, sample_count_o=0; next 8 samples of value 1 -> sum_o=8.
6. rst_ni low for 1 cycle after 5 accepts -> all outputs 0 the following cycle, state IDLE, no stats_valid_o.
